comm_mem_bridge: RTL and testbench
==================================

# comm_mem_bridge

Memory-side bridge directly downstream of the UART/JTAG communication subsystem. It accepts single-word and block read/write requests from the comm controller's request port (`req`, `req_block`, `rw`, `add`, `data`, `reqdev`, `clear`) and sequences them onto a single-outstanding, word-wide memory port with stall (`mem_wait`) and read-return (`mem_rvalid`). It returns per-word `valid`/`data` beats, a `done` pulse and `ready` to the comm controller.

## Interface
- BLOCK_WORDS, 4: words per block request; power of two, ≥ 2.
- BW_BLOCK, 2: log2(BLOCK_WORDS).
- clock_i  in  1  single clock for the whole block.
- resetn_i  in  1  reset: asynchronous, active-low.
- reqdev_i  in  3  requesting device ID; latched at accept.
- req_i  in  1  request strobe.
- req_block_i  in  1  1 = BLOCK_WORDS transfer, 0 = single word.
- rw_i  in  1  1 = write, 0 = read.
- add_i  in  27  byte address.
- data_i  in  32  write data, current word.
- clear_i  in  1  synchronous abort.
- ready_o  out  1  idle; can accept a request.
- valid_o  out  1  one-cycle beat: read word on data_o, or write word consumed.
- data_o  out  32  read data.
- done_o  out  1  one-cycle transfer-complete pulse.
- mem_req_o  out  1  memory request.
- mem_rw_o  out  1  1 = write.
- mem_dev_o  out  3  latched reqdev.
- mem_add_o  out  27  word-aligned byte address.
- mem_wdata_o  out  32  write data.
- mem_wait_i  in  1  memory stall; request held while high.
- mem_rvalid_i  in  1  read data return.
- mem_rdata_i  in  32  read data.

## Operation
- States: IDLE, WR_LOAD, WR_ISSUE, RD_ISSUE, RD_WAIT, RD_BEAT, DONE, DRAIN.
- Accept: `req_i && ready_o` in IDLE. Latches rw, block, reqdev and base address, then goes to WR_LOAD or RD_ISSUE. Word count = BLOCK_WORDS if block, else 1.
- Base address:
  - block: add_i with low BW_BLOCK+2 bits cleared;
  - single: add_i with low 2 bits cleared.
  - Each subsequent word adds 4, modulo 2^27.
- WR_LOAD: capture data_i into mem_wdata_o and assert valid_o this cycle. Requester presents the next word on data_i from the following cycle. Next state WR_ISSUE.
- WR_ISSUE: mem_req_o=1, mem_rw_o=1, held until a cycle with mem_wait_i=0. Then WR_LOAD if words remain, else DONE.
- RD_ISSUE: mem_req_o=1, mem_rw_o=0, held until mem_wait_i=0. Then RD_WAIT.
- RD_WAIT: wait for mem_rvalid_i. Capture mem_rdata_i into data_o, then go to RD_BEAT.
- RD_BEAT: valid_o=1. Then RD_ISSUE if words remain, else DONE.
- DONE: done_o=1 for one cycle, then IDLE.
- clear_i (any non-IDLE state) aborts the transfer; no done_o is produced.
  - In RD_WAIT, or in RD_ISSUE on a cycle where the request is accepted: go to DRAIN. DRAIN discards the next mem_rvalid_i, then goes to IDLE.
  - Otherwise: go to IDLE next cycle and drop mem_req_o.
  - clear_i in IDLE has no effect. clear_i has priority over all other transitions.
- mem_rvalid_i outside RD_WAIT/DRAIN is ignored.
- req_i while not ready is ignored; it is not queued.

## Timing
- Reset: state IDLE. All outputs 0, including ready_o.
- ready_o is registered: it is 1 from the first cycle after reset release while in IDLE, and falls the cycle after accept.
- All outputs are registered or Moore-decoded from state; no input→output combinational path.
- Write, zero stall: accept at t, valid_o at t+1, mem_req_o at t+2, next valid_o at t+3. That is 2 cycles/word. done_o at 2N+1, ready_o back at 2N+2.
- Read, rvalid one cycle after the request is accepted: accept at t, mem_req_o at t+1, rvalid at t+2, valid_o at t+3, next mem_req_o at t+4. That is 3 cycles/word.
- Each mem_wait_i cycle adds exactly one cycle, with mem_add_o/mem_wdata_o stable throughout.

## Structure
- Shared package `comm_mem_pkg`: state enum, default BLOCK_WORDS/BW_BLOCK, address width 27, data width 32.
- Single flat module; no sub-module (the word counter and address incrementer are inline).

## Test plan
- Single read, add_i=0x0000103, mem returns 0xDEADBEEF → mem_add_o=0x0000100, one valid_o with data_o=0xDEADBEEF, then done_o; ready_o back 1.
- Block write, add_i=0x0000014, data words 0x11..0x44 advanced on valid_o → four memory writes at 0x10, 0x14, 0x18, 0x1C with matching data, four valid_o beats, one done_o.
- Block read with mem_wait_i=1 for 3 cycles on word 2 → address held stable; 4 beats in order; total latency +3 cycles.
- Address wrap: block read at add_i=0x7FFFFF0 → addresses 0x7FFFFF0, 0x7FFFFF4, 0x7FFFFF8, 0x7FFFFFC; then single at 0x7FFFFFC.
- clear_i in RD_WAIT → no valid_o, no done_o; late mem_rvalid_i discarded; the next request completes correctly.
- resetn_i asserted mid-block-write → all outputs 0 immediately; ready_o=1 one cycle after release; a stray mem_rvalid_i is ignored.

Source files
------------

// File: rtl/comm_mem_pkg.sv
// comm_mem_pkg: shared definitions for the comm-to-memory bridge.
//   state_t          : bridge sequencer states
//   ADDR_W / DATA_W  : memory port address and data widths
//   DEF_BLOCK_WORDS  : default words per block request (power of two, >= 2)
//   DEF_BW_BLOCK     : log2(DEF_BLOCK_WORDS)
package comm_mem_pkg;

  localparam int ADDR_W          = 27;
  localparam int DATA_W          = 32;
  localparam int DEF_BLOCK_WORDS = 4;
  localparam int DEF_BW_BLOCK    = 2;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR_LOAD  = 3'd1,
    WR_ISSUE = 3'd2,
    RD_ISSUE = 3'd3,
    RD_WAIT  = 3'd4,
    RD_BEAT  = 3'd5,
    DONE     = 3'd6,
    DRAIN    = 3'd7
  } state_t;

endpackage

// File: rtl/comm_mem_bridge.sv
// comm_mem_bridge: sequences single-word and block read/write requests from
// the comm controller onto a single-outstanding, word-wide memory port.
//
// Ports
//   clock_i, resetn_i       : clock, asynchronous active-low reset
//   reqdev_i                : requesting device ID, latched at accept
//   req_i, req_block_i, rw_i: request strobe, block/single, write/read
//   add_i, data_i           : byte address, current write word
//   clear_i                 : synchronous abort of the active transfer
//   ready_o                 : idle, a request may be accepted
//   valid_o, data_o         : per-word beat (read word, or write word consumed)
//   done_o                  : one-cycle transfer-complete pulse
//   mem_req_o, mem_rw_o     : memory request, 1 = write
//   mem_dev_o, mem_add_o    : latched device ID, word-aligned byte address
//   mem_wdata_o             : memory write data
//   mem_wait_i              : memory stall, request held while high
//   mem_rvalid_i, mem_rdata_i : read data return
//
// Every output is a register updated from the next state, so no input has a
// combinational path to an output.
module comm_mem_bridge
  import comm_mem_pkg::*;
#(
  parameter int BLOCK_WORDS = DEF_BLOCK_WORDS,
  parameter int BW_BLOCK    = DEF_BW_BLOCK
) (
  input  logic                clock_i,
  input  logic                resetn_i,
  input  logic [2:0]          reqdev_i,
  input  logic                req_i,
  input  logic                req_block_i,
  input  logic                rw_i,
  input  logic [ADDR_W-1:0]   add_i,
  input  logic [DATA_W-1:0]   data_i,
  input  logic                clear_i,
  output logic                ready_o,
  output logic                valid_o,
  output logic [DATA_W-1:0]   data_o,
  output logic                done_o,
  output logic                mem_req_o,
  output logic                mem_rw_o,
  output logic [2:0]          mem_dev_o,
  output logic [ADDR_W-1:0]   mem_add_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  input  logic                mem_wait_i,
  input  logic                mem_rvalid_i,
  input  logic [DATA_W-1:0]   mem_rdata_i
);

  localparam int WL_W = BW_BLOCK + 1;

  // Block requests align to the whole block, singles to the word.
  localparam logic [ADDR_W-1:0] BLK_MASK  = {ADDR_W{1'b1}} << (BW_BLOCK + 2);
  localparam logic [ADDR_W-1:0] WORD_MASK = {ADDR_W{1'b1}} << 2;
  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(4);

  state_t          state;
  state_t          state_nxt;
  logic [WL_W-1:0] words_left;
  logic            accept;
  logic            issue_ok;

  assign accept   = (state == IDLE) && req_i && ready_o;
  assign issue_ok = ((state == WR_ISSUE) || (state == RD_ISSUE)) && !mem_wait_i;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (accept) state_nxt = rw_i ? WR_LOAD : RD_ISSUE;
      WR_LOAD:  state_nxt = WR_ISSUE;
      // words_left still counts the word being issued here.
      WR_ISSUE: if (!mem_wait_i)
                  state_nxt = (words_left == WL_W'(1)) ? DONE : WR_LOAD;
      RD_ISSUE: if (!mem_wait_i) state_nxt = RD_WAIT;
      RD_WAIT:  if (mem_rvalid_i) state_nxt = RD_BEAT;
      // words_left was already decremented when this word was issued.
      RD_BEAT:  state_nxt = (words_left == '0) ? DONE : RD_ISSUE;
      DONE:     state_nxt = IDLE;
      DRAIN:    if (mem_rvalid_i) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
    // Abort wins over everything. A read already accepted by memory still
    // owes one rvalid, which DRAIN swallows.
    if (clear_i && (state != IDLE)) begin
      if ((state == RD_WAIT) || ((state == RD_ISSUE) && !mem_wait_i))
        state_nxt = DRAIN;
      else
        state_nxt = IDLE;
    end
  end

  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state       <= IDLE;
      words_left  <= '0;
      ready_o     <= 1'b0;
      valid_o     <= 1'b0;
      done_o      <= 1'b0;
      mem_req_o   <= 1'b0;
      mem_rw_o    <= 1'b0;
      mem_dev_o   <= '0;
      mem_add_o   <= '0;
      mem_wdata_o <= '0;
      data_o      <= '0;
    end else begin
      state     <= state_nxt;
      ready_o   <= (state_nxt == IDLE);
      valid_o   <= (state_nxt == WR_LOAD) || (state_nxt == RD_BEAT);
      done_o    <= (state_nxt == DONE);
      mem_req_o <= (state_nxt == WR_ISSUE) || (state_nxt == RD_ISSUE);
      mem_rw_o  <= (state_nxt == WR_ISSUE);

      if (accept) begin
        mem_dev_o  <= reqdev_i;
        mem_add_o  <= add_i & (req_block_i ? BLK_MASK : WORD_MASK);
        words_left <= req_block_i ? WL_W'(BLOCK_WORDS) : WL_W'(1);
      end

      if (state == WR_LOAD)
        mem_wdata_o <= data_i;

      // Address advances only once memory takes the word, so it is stable
      // for the whole stall; wraps naturally at 2^ADDR_W.
      if (issue_ok) begin
        mem_add_o  <= mem_add_o + ADDR_STEP;
        words_left <= words_left - WL_W'(1);
      end

      if ((state == RD_WAIT) && mem_rvalid_i)
        data_o <= mem_rdata_i;
    end
  end

endmodule

// File: tb/tb_comm_mem_bridge.sv
module tb_comm_mem_bridge;

  typedef struct {
    logic        rw;
    logic [26:0] add;
    logic [31:0] wd;
    logic [2:0]  dev;
  } mop_t;

  typedef struct {
    logic        rd;
    logic [31:0] d;
  } beat_t;

  logic        clock_i = 1'b0;
  logic        resetn_i;
  logic [2:0]  reqdev_i;
  logic        req_i;
  logic        req_block_i;
  logic        rw_i;
  logic [26:0] add_i;
  logic [31:0] data_i;
  logic        clear_i;
  logic        ready_o;
  logic        valid_o;
  logic [31:0] data_o;
  logic        done_o;
  logic        mem_req_o;
  logic        mem_rw_o;
  logic [2:0]  mem_dev_o;
  logic [26:0] mem_add_o;
  logic [31:0] mem_wdata_o;
  logic        mem_wait_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  comm_mem_bridge dut (
    .clock_i      (clock_i),
    .resetn_i     (resetn_i),
    .reqdev_i     (reqdev_i),
    .req_i        (req_i),
    .req_block_i  (req_block_i),
    .rw_i         (rw_i),
    .add_i        (add_i),
    .data_i       (data_i),
    .clear_i      (clear_i),
    .ready_o      (ready_o),
    .valid_o      (valid_o),
    .data_o       (data_o),
    .done_o       (done_o),
    .mem_req_o    (mem_req_o),
    .mem_rw_o     (mem_rw_o),
    .mem_dev_o    (mem_dev_o),
    .mem_add_o    (mem_add_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_wait_i   (mem_wait_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i)
  );

  always #5 clock_i = ~clock_i;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int acc_cyc = 0;

  mop_t        exp_mem[$];
  beat_t       exp_beat[$];
  int          exp_done = 0;
  logic [31:0] rdq[$];
  bit          mon_en = 1'b0;

  // memory responder state
  int          rv_cnt     = -1;
  int          rv_delay   = 0;
  logic [31:0] rv_data    = '0;
  int          req_idx    = 0;
  int          stall_idx  = -1;
  int          stall_left = 0;

  always @(posedge clock_i) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Memory model: return read data rv_delay cycles after the accepted cycle
  // (0 = next cycle); optionally stall one chosen request for stall_left cycles.
  always @(posedge clock_i) begin
    #1;
    if (rv_cnt == 0) begin
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = rv_data;
      rv_cnt       = -1;
    end else begin
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = '0;
      if (rv_cnt > 0) rv_cnt--;
    end
    mem_wait_i = mem_req_o && (req_idx == stall_idx) && (stall_left > 0);
    if (mem_wait_i) stall_left--;
  end

  always @(negedge clock_i) begin
    if (resetn_i && mem_req_o && !mem_wait_i) begin
      req_idx++;
      if (!mem_rw_o) begin
        rv_data = (rdq.size() > 0) ? rdq.pop_front() : 32'hFFFF_FFFF;
        rv_cnt  = rv_delay;
      end
    end
  end

  // Scoreboard monitor
  always @(negedge clock_i) begin
    if (mon_en && resetn_i) begin
      if (mem_req_o) begin
        if (exp_mem.size() == 0) begin
          chk("unexpected_mem_req", 32'(mem_add_o), 32'h0FFF_FFFF);
        end else begin
          chk("mem_rw", 32'(mem_rw_o), 32'(exp_mem[0].rw));
          chk("mem_add", 32'(mem_add_o), 32'(exp_mem[0].add));
          chk("mem_dev", 32'(mem_dev_o), 32'(exp_mem[0].dev));
          if (exp_mem[0].rw) chk("mem_wdata", mem_wdata_o, exp_mem[0].wd);
          if (!mem_wait_i) void'(exp_mem.pop_front());
        end
      end
      if (valid_o) begin
        if (exp_beat.size() == 0) begin
          chk("unexpected_valid", 32'(valid_o), 32'h0);
        end else begin
          if (exp_beat[0].rd) chk("rd_data", data_o, exp_beat[0].d);
          else                chk("wr_beat", 32'(valid_o), 32'h1);
          void'(exp_beat.pop_front());
        end
      end
      if (done_o) begin
        chk("done_expected", 32'(exp_done > 0), 32'h1);
        if (exp_done > 0) exp_done--;
      end
    end
  end

  task automatic push_rd(input logic [26:0] a, input logic [2:0] dev, input logic [31:0] d);
    mop_t  m;
    beat_t b;
    m.rw = 1'b0; m.add = a; m.wd = '0; m.dev = dev;
    b.rd = 1'b1; b.d = d;
    exp_mem.push_back(m);
    exp_beat.push_back(b);
    rdq.push_back(d);
  endtask

  task automatic push_wr(input logic [26:0] a, input logic [2:0] dev, input logic [31:0] d);
    mop_t  m;
    beat_t b;
    m.rw = 1'b1; m.add = a; m.wd = d; m.dev = dev;
    b.rd = 1'b0; b.d = '0;
    exp_mem.push_back(m);
    exp_beat.push_back(b);
  endtask

  task automatic issue(input bit blk, input bit rw, input logic [26:0] a,
                       input logic [31:0] d0, input logic [2:0] dev);
    int n = 0;
    while (!ready_o && n < 60) begin @(posedge clock_i); #1; n++; end
    chk("ready_before_req", 32'(ready_o), 32'h1);
    req_i = 1'b1; req_block_i = blk; rw_i = rw; add_i = a; data_i = d0; reqdev_i = dev;
    @(posedge clock_i); #1;
    req_i   = 1'b0;
    acc_cyc = cyc;
  endtask

  task automatic wait_done(input int exp_lat, input string nm);
    int n = 0;
    while (!done_o && n < 200) begin @(posedge clock_i); #1; n++; end
    chk({nm, "_done"}, 32'(done_o), 32'h1);
    chk({nm, "_latency"}, 32'(cyc - acc_cyc), 32'(exp_lat));
    @(posedge clock_i); #1;
    chk({nm, "_ready_back"}, 32'(ready_o), 32'h1);
  endtask

  task automatic check_empty(input string nm);
    chk({nm, "_mem_left"}, 32'(exp_mem.size()), 32'h0);
    chk({nm, "_beat_left"}, 32'(exp_beat.size()), 32'h0);
    chk({nm, "_done_left"}, 32'(exp_done), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (got timeout, expected $finish)");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] wv [4];
    int n;
    wv[0] = 32'h11; wv[1] = 32'h22; wv[2] = 32'h33; wv[3] = 32'h44;

    resetn_i = 1'b0; reqdev_i = '0; req_i = 1'b0; req_block_i = 1'b0; rw_i = 1'b0;
    add_i = '0; data_i = '0; clear_i = 1'b0;
    mem_wait_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;

    repeat (3) @(posedge clock_i);
    #1;
    chk("rst_ready", 32'(ready_o), 32'h0);
    chk("rst_valid", 32'(valid_o), 32'h0);
    chk("rst_done", 32'(done_o), 32'h0);
    chk("rst_mem_req", 32'(mem_req_o), 32'h0);
    resetn_i = 1'b1;
    @(posedge clock_i); #1;
    chk("ready_after_rst", 32'(ready_o), 32'h1);
    mon_en = 1'b1;

    // single read, address aligned down to the word
    push_rd(27'h0000100, 3'd2, 32'hDEADBEEF);
    exp_done++;
    issue(1'b0, 1'b0, 27'h0000103, 32'h0, 3'd2);
    wait_done(3, "single_rd");
    check_empty("single_rd");

    // block write, requester advances data_i after each valid_o beat
    for (int i = 0; i < 4; i++) push_wr(27'h0000010 + 27'(4 * i), 3'd5, wv[i]);
    exp_done++;
    issue(1'b1, 1'b1, 27'h0000014, wv[0], 3'd5);
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (!valid_o && n < 20) begin @(posedge clock_i); #1; n++; end
      chk("blk_wr_valid_seen", 32'(valid_o), 32'h1);
      @(posedge clock_i); #1;
      if (k < 3) data_i = wv[k+1];
    end
    wait_done(8, "blk_wr");
    check_empty("blk_wr");

    // block read with a 3-cycle stall on the third word; a stray req_i
    // while busy must be ignored
    for (int i = 0; i < 4; i++) push_rd(27'h0000120 + 27'(4 * i), 3'd3, 32'h1000_0000 + 32'(i));
    exp_done++;
    stall_idx  = req_idx + 2;
    stall_left = 3;
    issue(1'b1, 1'b0, 27'h0000127, 32'h0, 3'd3);
    @(posedge clock_i); #1;
    req_i = 1'b1; rw_i = 1'b1; add_i = 27'h0000300;
    @(posedge clock_i); #1;
    req_i = 1'b0;
    wait_done(15, "blk_rd_stall");
    check_empty("blk_rd_stall");
    stall_idx = -1;

    // address near top of the space, then single at the very last word
    push_rd(27'h7FFFFF0, 3'd1, 32'hA000_0000);
    push_rd(27'h7FFFFF4, 3'd1, 32'hA000_0001);
    push_rd(27'h7FFFFF8, 3'd1, 32'hA000_0002);
    push_rd(27'h7FFFFFC, 3'd1, 32'hA000_0003);
    exp_done++;
    issue(1'b1, 1'b0, 27'h7FFFFF0, 32'h0, 3'd1);
    wait_done(12, "wrap_blk");
    push_rd(27'h7FFFFFC, 3'd1, 32'h5A5A_A5A5);
    exp_done++;
    issue(1'b0, 1'b0, 27'h7FFFFFF, 32'h0, 3'd1);
    wait_done(3, "wrap_single");
    check_empty("wrap");

    // clear in RD_WAIT: no beat, no done, late rvalid swallowed
    begin
      mop_t m;
      m.rw = 1'b0; m.add = 27'h0000200; m.wd = '0; m.dev = 3'd4;
      exp_mem.push_back(m);
      rdq.push_back(32'hBAD0_BAD0);
    end
    rv_delay = 3;
    issue(1'b0, 1'b0, 27'h0000200, 32'h0, 3'd4);
    @(posedge clock_i); #1;
    clear_i = 1'b1;
    @(posedge clock_i); #1;
    clear_i = 1'b0;
    n = 0;
    while (!ready_o && n < 30) begin @(posedge clock_i); #1; n++; end
    chk("clear_ready_back", 32'(ready_o), 32'h1);
    rv_delay = 0;
    push_rd(27'h0000300, 3'd4, 32'hCAFE_F00D);
    exp_done++;
    issue(1'b0, 1'b0, 27'h0000301, 32'h0, 3'd4);
    wait_done(3, "after_clear");
    check_empty("clear");

    // reset in the middle of a block write
    mon_en = 1'b0;
    issue(1'b1, 1'b1, 27'h0000040, 32'h55, 3'd6);
    repeat (2) @(posedge clock_i);
    #3;
    resetn_i = 1'b0;
    #1;
    chk("midrst_ready", 32'(ready_o), 32'h0);
    chk("midrst_valid", 32'(valid_o), 32'h0);
    chk("midrst_done", 32'(done_o), 32'h0);
    chk("midrst_mem_req", 32'(mem_req_o), 32'h0);
    chk("midrst_mem_rw", 32'(mem_rw_o), 32'h0);
    chk("midrst_mem_dev", 32'(mem_dev_o), 32'h0);
    chk("midrst_mem_add", 32'(mem_add_o), 32'h0);
    chk("midrst_mem_wdata", mem_wdata_o, 32'h0);
    chk("midrst_data", data_o, 32'h0);
    @(posedge clock_i); #1;
    exp_mem.delete(); exp_beat.delete(); rdq.delete(); exp_done = 0;
    data_i = '0;
    resetn_i = 1'b1;
    chk("rel_ready_low", 32'(ready_o), 32'h0);
    rv_data = 32'h0BAD_0BAD;
    rv_cnt  = 0;
    mon_en  = 1'b1;
    @(posedge clock_i); #1;
    chk("rel_ready_high", 32'(ready_o), 32'h1);
    repeat (2) @(posedge clock_i);
    #1;
    push_rd(27'h0000080, 3'd7, 32'h600D_F00D);
    exp_done++;
    issue(1'b0, 1'b0, 27'h0000082, 32'h0, 3'd7);
    wait_done(3, "after_reset");
    check_empty("reset");

    repeat (2) @(posedge clock_i);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
